// File: rtl/decimator.sv
// decimator: sample-and-hold downsampler by factor M.
// Captures di_i on each strobe cycle, holds it until the next capture, and
// raises a sticky flag whenever two armed strobes are not exactly M cycles apart.
module decimator #(
    parameter int M    = 20,
    parameter int M_LG = 5,
    parameter int DW   = 14
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 clk_2mhz_pos_en_i,
    input  logic                 ce_i,
    input  logic signed [DW-1:0] di_i,
    output logic signed [DW-1:0] do_o,
    output logic                 do_valid_o,
    output logic                 err_o
);

    // The phase counter must be able to reach M-1.
    generate
        if (M < 1 || (2 ** M_LG) < M) begin : g_bad_params
            $error("decimator: need M >= 1 and 2**M_LG >= M");
        end
    endgenerate

    localparam logic [M_LG-1:0] CNT_LAST = M_LG'(M - 1);

    logic signed [DW-1:0] do_q,    do_d;
    logic                 valid_q, valid_d;
    logic                 err_q,   err_d;
    logic [M_LG-1:0]      cnt_q,   cnt_d;
    logic                 armed_q, armed_d;
    // Set when a non-strobe cycle occurs with the counter already saturated,
    // i.e. the gap since the last strobe has exceeded M. The saturated counter
    // alone cannot tell spacing M from a longer gap, so this bit does.
    logic                 late_q,  late_d;

    // Next-state logic: flush when disabled, capture/check on strobe, count otherwise.
    always_comb begin
        do_d    = do_q;
        valid_d = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        late_d  = late_q;
        if (!ce_i) begin
            do_d    = '0;
            cnt_d   = '0;
            armed_d = 1'b0;
            late_d  = 1'b0;
        end else if (clk_2mhz_pos_en_i) begin
            do_d    = di_i;
            valid_d = 1'b1;
            // First strobe after reset or re-enable is not checked.
            if (armed_q && ((cnt_q != CNT_LAST) || late_q)) begin
                err_d = 1'b1;
            end
            cnt_d   = '0;
            armed_d = 1'b1;
            late_d  = 1'b0;
        end else begin
            if (cnt_q == CNT_LAST) begin
                late_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            do_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            late_q  <= 1'b0;
        end else begin
            do_q    <= do_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            late_q  <= late_d;
        end
    end

    assign do_o       = do_q;
    assign do_valid_o = valid_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_decimator.sv
// Testbench for decimator: directed scenarios plus randomized strobe spacing,
// checked every cycle against a timestamp-based reference model.
module tb_decimator;

    localparam int M    = 20;
    localparam int M_LG = 5;
    localparam int DW   = 14;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stb = 1'b0;
    logic          ce = 1'b0;
    logic [DW-1:0] di = '0;
    logic [DW-1:0] do_w;
    logic          valid_w;
    logic          err_w;

    int compared   = 0;
    int mismatched = 0;
    bit chk_en     = 1'b0;

    decimator #(.M(M), .M_LG(M_LG), .DW(DW)) dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .clk_2mhz_pos_en_i (stb),
        .ce_i              (ce),
        .di_i              (di),
        .do_o              (do_w),
        .do_valid_o        (valid_w),
        .err_o             (err_w)
    );

    always #5 clk = ~clk;

    // Reference model: remembers when the last strobe happened and compares
    // the elapsed cycle count with M directly.
    longint        now      = 0;
    longint        last_stb = 0;
    bit            armed    = 1'b0;
    logic [DW-1:0] exp_do    = '0;
    logic          exp_valid = 1'b0;
    logic          exp_err   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed     = 1'b0;
            exp_do    = '0;
            exp_valid = 1'b0;
            exp_err   = 1'b0;
        end else begin
            if (!ce) begin
                exp_do    = '0;
                exp_valid = 1'b0;
                armed     = 1'b0;
            end else if (stb) begin
                if (armed && (now - last_stb) != M) exp_err = 1'b1;
                exp_do    = di;
                exp_valid = 1'b1;
                armed     = 1'b1;
                last_stb  = now;
            end else begin
                exp_valid = 1'b0;
            end
            now++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("model_do", {18'b0, do_w}, {18'b0, exp_do});
            chk("model_valid", {31'b0, valid_w}, {31'b0, exp_valid});
            chk("model_err", {31'b0, err_w}, {31'b0, exp_err});
        end
    end

    // One clock cycle with the given inputs; returns 1 ns after the edge.
    task automatic tick(input logic c, input logic s, input logic [DW-1:0] d);
        ce  = c;
        stb = s;
        di  = d;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear with no edge.
    task automatic do_reset(input string tag);
        ce    = 1'b0;
        stb   = 1'b0;
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_do"}, {18'b0, do_w}, 32'h0);
        chk({tag, "_rst_valid"}, {31'b0, valid_w}, 32'h0);
        chk({tag, "_rst_err"}, {31'b0, err_w}, 32'h0);
        $display("reset %s: do=0x%0h valid=%0b err=%0b", tag, do_w, valid_w, err_w);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] saved;
    int            gap;

    initial begin
        do_reset("init");
        chk_en = 1'b1;

        // Normal capture: ramping input, strobes every M cycles from cycle 5.
        for (int c = 0; c < 86; c++) begin
            logic s;
            logic [DW-1:0] d;
            s = (c >= 5) && ((c - 5) % M == 0);
            d = DW'(c);
            if (c == 85) d = 14'h2000;
            tick(1'b1, s, d);
            if (s) begin
                chk("ramp_capture", {18'b0, do_w}, (c == 85) ? 32'h2000 : c);
                chk("ramp_valid", {31'b0, valid_w}, 32'h1);
                $display("strobe c=%0d do=0x%0h valid=%0b err=%0b", c, do_w, valid_w, err_w);
            end
            if (c == 6) chk("ramp_valid_low", {31'b0, valid_w}, 32'h0);
        end
        // Negative sample held for the full output period.
        for (int c = 0; c < M - 1; c++) tick(1'b1, 1'b0, DW'(c));
        chk("neg_hold", {18'b0, do_w}, 32'h2000);
        chk("ramp_err", {31'b0, err_w}, 32'h0);
        $display("neg hold: do=0x%0h err=%0b", do_w, err_w);

        // ce drop: flush, disarm, then a re-armed strobe pair passes the check.
        for (int c = 0; c < 7; c++) begin
            tick(1'b0, (c == 3), 14'h1111);
            chk("ce_off_do", {18'b0, do_w}, 32'h0);
        end
        for (int c = 0; c < 3 + 2 * M + 1; c++) begin
            logic s;
            s = (c == 3) || (c == 3 + M) || (c == 3 + 2 * M);
            tick(1'b1, s, DW'(100 + c));
        end
        chk("ce_drop_err", {31'b0, err_w}, 32'h0);
        chk("ce_drop_do", {18'b0, do_w}, 32'd143);
        $display("ce drop: do=0x%0h err=%0b", do_w, err_w);

        // Early strobe: strobes at 0, 20, 35. Capture 0x1234 first for the reset check.
        tick(1'b1, 1'b1, 14'h1234);
        chk("pre_reset_do", {18'b0, do_w}, 32'h1234);
        do_reset("early");
        for (int c = 0; c <= 40; c++) begin
            logic s;
            logic [DW-1:0] d;
            s = (c == 0) || (c == 20) || (c == 35);
            d = DW'($urandom);
            if (c == 35) saved = d;
            tick(1'b1, s, d);
            if (c == 34) chk("early_err_before", {31'b0, err_w}, 32'h0);
            if (c == 35) begin
                chk("early_err_after", {31'b0, err_w}, 32'h1);
                chk("early_do", {18'b0, do_w}, {18'b0, saved});
                $display("early strobe: do=0x%0h err=%0b", do_w, err_w);
            end
        end

        // Late strobe: strobes at 0 and 45.
        do_reset("late");
        for (int c = 0; c <= 50; c++) begin
            tick(1'b1, (c == 0) || (c == 45), DW'($urandom));
            if (c == 44) chk("late_err_before", {31'b0, err_w}, 32'h0);
            if (c == 45) begin
                chk("late_err_after", {31'b0, err_w}, 32'h1);
                $display("late strobe: err=%0b", err_w);
            end
        end
        // err_o is sticky through ce drop.
        tick(1'b0, 1'b0, '0);
        chk("err_sticky", {31'b0, err_w}, 32'h1);

        // Randomized segments with mostly-correct spacing.
        for (int seg = 0; seg < 15; seg++) begin
            int errs_before;
            errs_before = mismatched;
            do_reset("rand");
            gap = 0;
            for (int c = 0; c < 200; c++) begin
                logic cc;
                logic s;
                cc = ($urandom_range(0, 39) != 0);
                s  = 1'b0;
                if (gap == 0) begin
                    int r;
                    s = 1'b1;
                    r = $urandom_range(0, 9);
                    if (r < 7)       gap = M - 1;
                    else if (r == 7) gap = $urandom_range(0, M - 2);
                    else if (r == 8) gap = M + $urandom_range(0, 4);
                    else             gap = 0;
                end else begin
                    gap--;
                end
                tick(cc, s, DW'($urandom));
            end
            $display("random seg %0d: err=%0b new_mismatches=%0d", seg, err_w, mismatched - errs_before);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
